sata_dma_arb: RTL and testbench



---
 rtl/sata_dma_pkg.sv | 15 +
 rtl/sata_rr_pick3.sv | 31 +++
 rtl/sata_dma_arb.sv | 163 ++++++++++++++++
 tb/tb_sata_dma_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_dma_pkg.sv
// Shared definitions for the SATA DMA request arbiter: FSM encoding,
// requester count, idle owner code and timeout counter width.
package sata_dma_pkg;

  localparam int unsigned NREQ       = 3;
  localparam logic [1:0]  OWNER_NONE = 2'd3;
  localparam int unsigned TMO_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sata_rr_pick3.sv
// Combinational round-robin picker over three requesters: first set bit of
// valid searching ptr, ptr+1, ptr+2 (mod 3).
module sata_rr_pick3
  import sata_dma_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      ptr,
  output logic [1:0]      index,
  output logic            found
);

  logic [2:0] sum;
  logic [1:0] cand;

  always_comb begin
    index = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
      cand = sum[1:0];
      if (!found && valid[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/sata_dma_arb.sv
// Round-robin arbiter granting one of three DMA requesters to a single DMA
// engine. Optional REQ-phase abort timer enabled by SATA_DMA_ARB_TIMEOUT_EN.
module sata_dma_arb
  import sata_dma_pkg::*;
#(
  parameter logic [TMO_W-1:0] C_TIMEOUT = 16'hFFFF,
  parameter int unsigned      C_PORT    = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_address,
  input  logic [16*NREQ-1:0]   req_length,
  input  logic [NREQ-1:0]      req_wrt,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic                 dma_req,
  output logic [31:0]          dma_address,
  output logic [15:0]          dma_length,
  output logic                 dma_wrt,
  input  logic                 dma_ack,
  output logic [1:0]           owner,
  output logic                 busy,
  input  logic                 timeout_clr,
  output logic                 timeout_stat
);

  arb_state_e      state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [31:0]     addr_q, addr_d;
  logic [15:0]     len_q, len_d;
  logic            wrt_q, wrt_d;
  logic            dma_req_q, dma_req_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [1:0]      pick_idx;
  logic            pick_found;
  logic            unused_cfg;
`ifdef SATA_DMA_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_stat_q, tmo_stat_d;
  logic [NREQ-1:0]  err_q, err_d;
`endif

  sata_rr_pick3 u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .index (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wrt_d     = wrt_q;
    dma_req_d = dma_req_q;
    done_d    = '0;
`ifdef SATA_DMA_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_stat_d = timeout_clr ? 1'b0 : tmo_stat_q;
    err_d      = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d   = ST_REQ;
          owner_d   = pick_idx;
          rr_ptr_d  = (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
          addr_d    = req_address[{pick_idx, 5'd0} +: 32];
          len_d     = req_length[{pick_idx, 4'd0} +: 16];
          wrt_d     = req_wrt[pick_idx];
          dma_req_d = 1'b1;
`ifdef SATA_DMA_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_REQ: begin
        // ack is checked first so an ack on the match cycle completes normally
        if (dma_ack) begin
          state_d         = ST_DONE;
          dma_req_d       = 1'b0;
          done_d[owner_q] = 1'b1;
        end
`ifdef SATA_DMA_ARB_TIMEOUT_EN
        else if (tmo_cnt_q + 1'b1 == C_TIMEOUT) begin
          state_d        = ST_IDLE;
          dma_req_d      = 1'b0;
          owner_d        = OWNER_NONE;
          err_d[owner_q] = 1'b1;
          tmo_stat_d     = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWNER_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_NONE;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      wrt_q     <= 1'b0;
      dma_req_q <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wrt_q     <= wrt_d;
      dma_req_q <= dma_req_d;
      done_q    <= done_d;
    end
  end

`ifdef SATA_DMA_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt_q  <= '0;
      tmo_stat_q <= 1'b0;
      err_q      <= '0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_stat_q <= tmo_stat_d;
      err_q      <= err_d;
    end
  end

  assign req_err      = err_q;
  assign timeout_stat = tmo_stat_q;
  assign unused_cfg   = ^{C_PORT};
`else
  assign req_err      = '0;
  assign timeout_stat = 1'b0;
  assign unused_cfg   = ^{C_PORT, C_TIMEOUT, timeout_clr};
`endif

  assign req_done    = done_q;
  assign dma_req     = dma_req_q;
  assign dma_address = addr_q;
  assign dma_length  = len_q;
  assign dma_wrt     = wrt_q;
  assign owner       = owner_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sata_dma_arb.sv
// Scoreboard bench for sata_dma_arb; timeout cases build with SATA_DMA_ARB_TIMEOUT_EN.
module tb_sata_dma_arb;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [2:0]  req_valid;
  logic [95:0] req_address;
  logic [47:0] req_length;
  logic [2:0]  req_wrt;
  logic [2:0]  req_done;
  logic [2:0]  req_err;
  logic        dma_req;
  logic [31:0] dma_address;
  logic [15:0] dma_length;
  logic        dma_wrt;
  logic        dma_ack;
  logic [1:0]  owner;
  logic        busy;
  logic        timeout_clr;
  logic        timeout_stat;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] addr;
    logic [15:0] len;
    logic        wrt;
  } grant_t;

  grant_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] ADDR0 = 32'hA000_0000;
  localparam logic [31:0] ADDR1 = 32'h1000_0000;
  localparam logic [31:0] ADDR2 = 32'hC000_0040;
  localparam logic [15:0] LEN0  = 16'h0010;
  localparam logic [15:0] LEN1  = 16'h0200;
  localparam logic [15:0] LEN2  = 16'h0333;
  localparam logic [2:0]  WRT   = 3'b101;

  sata_dma_arb #(.C_TIMEOUT(16'd16), .C_PORT(0)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .req_length   (req_length),
    .req_wrt      (req_wrt),
    .req_done     (req_done),
    .req_err      (req_err),
    .dma_req      (dma_req),
    .dma_address  (dma_address),
    .dma_length   (dma_length),
    .dma_wrt      (dma_wrt),
    .dma_ack      (dma_ack),
    .owner        (owner),
    .busy         (busy),
    .timeout_clr  (timeout_clr),
    .timeout_stat (timeout_stat)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic grant_t exp_of(input int i);
    grant_t g;
    g.own = 2'(i);
    case (i)
      0: begin g.addr = ADDR0; g.len = LEN0; end
      1: begin g.addr = ADDR1; g.len = LEN1; end
      default: begin g.addr = ADDR2; g.len = LEN2; end
    endcase
    g.wrt = WRT[i];
    return g;
  endfunction

  // Waits (bounded) for dma_req, then compares the grant against the scoreboard head.
  task automatic wait_grant(output grant_t g);
    int n = 0;
    while (dma_req !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("grant_seen", 32'(dma_req), 32'd1);
    if (exp_q.size() == 0) begin
      check_eq("sb_nonempty", 32'd0, 32'd1);
      g = exp_of(0);
    end else begin
      g = exp_q.pop_front();
    end
    check_eq("owner", 32'(owner), 32'(g.own));
    check_eq("dma_address", dma_address, g.addr);
    check_eq("dma_length", 32'(dma_length), 32'(g.len));
    check_eq("dma_wrt", 32'(dma_wrt), 32'(g.wrt));
    check_eq("busy_req", 32'(busy), 32'd1);
  endtask

  task automatic run_txn(input int ack_delay, input bit drop);
    grant_t g;
    wait_grant(g);
    if (drop) req_valid = '0;
    repeat (ack_delay) @(negedge sys_clk);
    check_eq("dma_req_held", 32'(dma_req), 32'd1);
    dma_ack = 1'b1;
    @(negedge sys_clk);
    dma_ack = 1'b0;
    check_eq("dma_req_low", 32'(dma_req), 32'd0);
    check_eq("req_done", 32'(req_done), 32'(3'b001 << g.own));
    check_eq("req_err_none", 32'(req_err), 32'd0);
    @(negedge sys_clk);
    check_eq("req_done_1cyc", 32'(req_done), 32'd0);
    check_eq("owner_idle", 32'(owner), 32'd3);
    check_eq("addr_stable", dma_address, g.addr);
  endtask

  initial begin
    grant_t g;
    int n;
    logic [2:0] seen;
    sys_rst_n   = 1'b0;
    req_valid   = '0;
    req_address = {ADDR2, ADDR1, ADDR0};
    req_length  = {LEN2, LEN1, LEN0};
    req_wrt     = WRT;
    dma_ack     = 1'b0;
    timeout_clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_owner", 32'(owner), 32'd3);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dma_req", 32'(dma_req), 32'd0);
    check_eq("rst_addr", dma_address, 32'd0);
    check_eq("rst_len", 32'(dma_length), 32'd0);
    check_eq("rst_wrt", 32'(dma_wrt), 32'd0);
    check_eq("rst_done_err", 32'({req_done, req_err}), 32'd0);
    check_eq("rst_tstat", 32'(timeout_stat), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // all three held: round-robin order 0,1,2,0
    req_valid = 3'b111;
    exp_q.push_back(exp_of(0));
    exp_q.push_back(exp_of(1));
    exp_q.push_back(exp_of(2));
    exp_q.push_back(exp_of(0));
    for (int i = 0; i < 4; i++) run_txn(1, 1'b0);
    req_valid = '0;

    // rr_ptr now 1: {0,2} pending picks 2; drop req_valid during REQ
    req_valid = 3'b101;
    exp_q.push_back(exp_of(2));
    @(negedge sys_clk);
    run_txn(2, 1'b1);

    // single requester 1, ack 5 cycles after dma_req
    req_valid = 3'b010;
    exp_q.push_back(exp_of(1));
    @(negedge sys_clk);
    check_eq("dma_req_1cyc", 32'(dma_req), 32'd1);
    run_txn(4, 1'b1);

    // ack in IDLE ignored, then normal grant of requester 0
    dma_ack = 1'b1;
    @(negedge sys_clk);
    dma_ack = 1'b0;
    check_eq("idle_ack_busy", 32'(busy), 32'd0);
    check_eq("idle_ack_done", 32'(req_done), 32'd0);
    req_valid = 3'b001;
    exp_q.push_back(exp_of(0));
    run_txn(1, 1'b1);

`ifdef SATA_DMA_ARB_TIMEOUT_EN
    // no ack: abort after 16 REQ cycles; clr on the abort cycle loses
    req_valid = 3'b001;
    exp_q.push_back(exp_of(0));
    wait_grant(g);
    n = 0;
    while (dma_req === 1'b1 && n < 100) begin
      n++;
      if (n == 16) timeout_clr = 1'b1;
      @(negedge sys_clk);
    end
    timeout_clr = 1'b0;
    req_valid   = '0;
    check_eq("tmo_cycles", 32'(n), 32'd16);
    check_eq("tmo_err", 32'(req_err), 32'b001);
    check_eq("tmo_no_done", 32'(req_done), 32'd0);
    check_eq("tmo_stat", 32'(timeout_stat), 32'd1);
    check_eq("tmo_owner", 32'(owner), 32'd3);
    @(negedge sys_clk);
    check_eq("tmo_err_1cyc", 32'(req_err), 32'd0);
    check_eq("tmo_stat_sticky", 32'(timeout_stat), 32'd1);
    timeout_clr = 1'b1;
    @(negedge sys_clk);
    timeout_clr = 1'b0;
    check_eq("tmo_stat_clr", 32'(timeout_stat), 32'd0);

    // ack on the 16th REQ cycle wins over the timeout
    req_valid = 3'b001;
    exp_q.push_back(exp_of(0));
    wait_grant(g);
    for (int i = 1; i < 16; i++) @(negedge sys_clk);
    check_eq("ack16_req_held", 32'(dma_req), 32'd1);
    dma_ack = 1'b1;
    @(negedge sys_clk);
    dma_ack   = 1'b0;
    req_valid = '0;
    check_eq("ack16_done", 32'(req_done), 32'b001);
    check_eq("ack16_no_err", 32'(req_err), 32'd0);
    check_eq("ack16_stat", 32'(timeout_stat), 32'd0);
    @(negedge sys_clk);
`else
    // no timer: REQ waits indefinitely
    req_valid = 3'b001;
    exp_q.push_back(exp_of(0));
    wait_grant(g);
    repeat (40) @(negedge sys_clk);
    check_eq("notmo_req_held", 32'(dma_req), 32'd1);
    check_eq("notmo_err", 32'(req_err), 32'd0);
    dma_ack = 1'b1;
    @(negedge sys_clk);
    dma_ack   = 1'b0;
    req_valid = '0;
    check_eq("notmo_done", 32'(req_done), 32'b001);
    @(negedge sys_clk);
`endif

    // reset mid-REQ abandons the transfer silently
    req_valid = 3'b100;
    exp_q.push_back(exp_of(2));
    wait_grant(g);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_eq("arst_dma_req", 32'(dma_req), 32'd0);
    check_eq("arst_owner", 32'(owner), 32'd3);
    check_eq("arst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seen = '0;
    repeat (4) begin
      @(negedge sys_clk);
      seen = seen | req_done;
    end
    check_eq("arst_no_done", 32'(seen), 32'd0);

    // rr_ptr back to 0 after reset
    req_valid = 3'b111;
    exp_q.push_back(exp_of(0));
    run_txn(1, 1'b1);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
